// File: rtl/spi_voice_regfile.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_voice_regfile: byte-stream register file for N voice dividers behind SPI.
// Rev 1.0
// ----------------------------------------------------------------------------
module spi_voice_regfile #(
  parameter int             N_VOICES  = 8,
  parameter int             D_W       = 16,
  parameter logic [D_W-1:0] RESET_DIV = '0,
  parameter logic [7:0]     ACK_BYTE  = 8'hFF
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    cs_active,
  input  logic                    rx_byte_valid,
  input  logic [7:0]              rx_byte,
  output logic [7:0]              tx_byte,
  output logic [N_VOICES*D_W-1:0] voice_div,
  output logic [N_VOICES-1:0]     voice_wr_stb,
  output logic                    cmd_err
);
  localparam int            BPR         = D_W / 8;
  localparam int            BW          = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [BW-1:0] C_LAST_BYTE = BW'(BPR - 1);
  localparam logic [5:0]    C_LAST_IDX  = 6'(N_VOICES - 1);
  localparam logic [7:0]    C_NAK       = 8'h00;

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2} state_t;

  state_t              state_q, state_d;
  logic                armed_q, armed_d;
  logic                wr_q, wr_d;
  logic                ainc_q, ainc_d;
  logic [5:0]          idx_q, idx_d;
  logic [BW-1:0]       byte_idx_q, byte_idx_d;
  logic [D_W-1:0]      shadow_q, shadow_d;
  logic [D_W-1:0]      sr_q, sr_d;
  logic [7:0]          tx_q, tx_d;
  logic [N_VOICES-1:0] stb_q, stb_d;
  logic                err_q, err_d;
  logic [D_W-1:0]      voice_q [N_VOICES];
  logic [D_W-1:0]      voice_d [N_VOICES];

  logic [5:0]          next_idx;
  logic [5:0]          rd_sel;
  logic [D_W-1:0]      rd_word;
  logic                last_byte;

  function automatic logic valid_idx(input logic [5:0] i);
    return i <= C_LAST_IDX;
  endfunction

  // Auto-increment wraps to 0 from the last voice and from any invalid index.
  assign next_idx  = !ainc_q ? idx_q : ((idx_q >= C_LAST_IDX) ? 6'd0 : idx_q + 6'd1);
  assign last_byte = (byte_idx_q == C_LAST_BYTE);
  assign rd_sel    = (state_q == CMD) ? rx_byte[5:0] : next_idx;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < N_VOICES; k++) begin
      if (rd_sel == 6'(k)) rd_word = voice_q[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q | ~cs_active;
    wr_d       = wr_q;
    ainc_d     = ainc_q;
    idx_d      = idx_q;
    byte_idx_d = byte_idx_q;
    shadow_d   = shadow_q;
    sr_d       = sr_q;
    tx_d       = tx_q;
    stb_d      = '0;
    err_d      = err_q;
    voice_d    = voice_q;
    unique case (state_q)
      IDLE: begin
        byte_idx_d = '0;
        if (cs_active && armed_q) state_d = CMD;
      end
      CMD: begin
        if (rx_byte_valid) begin
          wr_d       = rx_byte[7];
          ainc_d     = rx_byte[6];
          idx_d      = rx_byte[5:0];
          byte_idx_d = '0;
          state_d    = DATA;
          if (rx_byte[7]) begin
            tx_d = valid_idx(rx_byte[5:0]) ? ACK_BYTE : C_NAK;
          end else begin
            tx_d = valid_idx(rx_byte[5:0]) ? rd_word[D_W-1 -: 8] : C_NAK;
            sr_d = rd_word << 8;
          end
          if (!rx_byte[7] && rx_byte[5:0] == 6'h3F) err_d = 1'b0;
          else if (!valid_idx(rx_byte[5:0]))        err_d = 1'b1;
        end
        if (!cs_active) state_d = IDLE;
      end
      DATA: begin
        if (rx_byte_valid) begin
          if (wr_q) begin
            shadow_d = (shadow_q << 8) | D_W'(rx_byte);
            tx_d     = valid_idx(idx_q) ? ACK_BYTE : C_NAK;
            if (last_byte && valid_idx(idx_q)) begin
              for (int k = 0; k < N_VOICES; k++) begin
                if (idx_q == 6'(k)) begin
                  voice_d[k] = shadow_d;
                  stb_d[k]   = 1'b1;
                end
              end
            end
          end else if (last_byte) begin
            tx_d = valid_idx(next_idx) ? rd_word[D_W-1 -: 8] : C_NAK;
            sr_d = rd_word << 8;
          end else begin
            tx_d = valid_idx(idx_q) ? sr_q[D_W-1 -: 8] : C_NAK;
            sr_d = sr_q << 8;
          end
          if (last_byte) begin
            byte_idx_d = '0;
            idx_d      = next_idx;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
        // A partially written shadow is simply abandoned here.
        if (!cs_active) begin
          state_d    = IDLE;
          byte_idx_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      wr_q       <= 1'b0;
      ainc_q     <= 1'b0;
      idx_q      <= '0;
      byte_idx_q <= '0;
      shadow_q   <= '0;
      sr_q       <= '0;
      tx_q       <= 8'h00;
      stb_q      <= '0;
      err_q      <= 1'b0;
      for (int k = 0; k < N_VOICES; k++) voice_q[k] <= RESET_DIV;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      wr_q       <= wr_d;
      ainc_q     <= ainc_d;
      idx_q      <= idx_d;
      byte_idx_q <= byte_idx_d;
      shadow_q   <= shadow_d;
      sr_q       <= sr_d;
      tx_q       <= tx_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
      voice_q    <= voice_d;
    end
  end

  assign tx_byte      = tx_q;
  assign voice_wr_stb = stb_q;
  assign cmd_err      = err_q;

  generate
    for (genvar g = 0; g < N_VOICES; g++) begin : g_flat
      assign voice_div[g*D_W +: D_W] = voice_q[g];
    end
  endgenerate
endmodule
`default_nettype wire

// File: tb/tb_spi_voice_regfile.sv
`default_nettype none
// tb_spi_voice_regfile: directed vector table, hand sequences for frame corner
// cases, and random frames checked against a frame-level behavioural model.
module tb_spi_voice_regfile;
  logic         clk = 1'b0;
  logic         sys_rst, cs_active, rx_byte_valid;
  logic [7:0]   rx_byte;
  logic [7:0]   tx_byte, tx24;
  logic [127:0] voice_div;
  logic [95:0]  voice_div24;
  logic [7:0]   voice_wr_stb;
  logic [3:0]   stb24;
  logic         cmd_err, err24;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  spi_voice_regfile dut (
    .sys_clk(clk), .sys_rst(sys_rst), .cs_active(cs_active),
    .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte), .tx_byte(tx_byte),
    .voice_div(voice_div), .voice_wr_stb(voice_wr_stb), .cmd_err(cmd_err));

  spi_voice_regfile #(.N_VOICES(4), .D_W(24)) dut24 (
    .sys_clk(clk), .sys_rst(sys_rst), .cs_active(cs_active),
    .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte), .tx_byte(tx24),
    .voice_div(voice_div24), .voice_wr_stb(stb24), .cmd_err(err24));

  // Reference model: frame position arithmetic over 8 x 16-bit voices.
  logic [15:0] m_voice [8];
  logic        m_err;
  bit          m_wr, m_ai, track;
  int          m_idx, m_pos;
  logic [15:0] m_acc;
  logic [7:0]  m_tx, m_stb;

  task automatic m_reset();
    for (int k = 0; k < 8; k++) m_voice[k] = 16'h0000;
    m_err = 1'b0;
  endtask

  function automatic int adv(input int i);
    if (!m_ai) return i;
    return (i >= 7) ? 0 : i + 1;
  endfunction

  task automatic m_byte(input bit first, input logic [7:0] b);
    m_stb = 8'h00;
    if (first) begin
      m_wr  = b[7];
      m_ai  = b[6];
      m_idx = int'(b[5:0]);
      m_pos = 0;
      if (!m_wr && m_idx == 63) m_err = 1'b0;
      else if (m_idx >= 8)      m_err = 1'b1;
      if (m_wr) m_tx = (m_idx < 8) ? 8'hFF : 8'h00;
      else      m_tx = (m_idx < 8) ? m_voice[m_idx[2:0]][15:8] : 8'h00;
    end else if (m_wr) begin
      m_acc = {m_acc[7:0], b};
      m_tx  = (m_idx < 8) ? 8'hFF : 8'h00;
      if (m_pos == 1) begin
        if (m_idx < 8) begin
          m_voice[m_idx[2:0]] = m_acc;
          m_stb = 8'h01 << m_idx[2:0];
        end
        m_idx = adv(m_idx);
      end
      m_pos = 1 - m_pos;
    end else begin
      if (m_pos == 0) begin
        m_tx = (m_idx < 8) ? m_voice[m_idx[2:0]][7:0] : 8'h00;
      end else begin
        m_idx = adv(m_idx);
        m_tx  = (m_idx < 8) ? m_voice[m_idx[2:0]][15:8] : 8'h00;
      end
      m_pos = 1 - m_pos;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input bit first, input bit drop);
    @(negedge clk);
    rx_byte_valid = 1'b1;
    rx_byte       = b;
    if (drop) cs_active = 1'b0;
    @(negedge clk);
    rx_byte_valid = 1'b0;
    if (track) m_byte(first, b);
  endtask

  task automatic frame_start();
    @(negedge clk);
    cs_active = 1'b1;
  endtask

  task automatic frame_end();
    @(negedge clk);
    cs_active = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_model_voices(input string tag);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s v%0d", tag, k), 32'(voice_div[k*16 +: 16]), 32'(m_voice[k]));
  endtask

  typedef struct {
    int          n;
    logic [47:0] b;
    logic [47:0] tx;
    logic [47:0] stb;
    logic        err;
    int          vi;
    logic [15:0] vv;
  } vec_t;
  vec_t tbl [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{n:3, b:48'h831234000000, tx:48'hFFFFFF000000, stb:48'h000008000000, err:1'b0, vi:3, vv:16'h1234};
    tbl[1] = '{n:5, b:48'hC7AABBCCDD00, tx:48'hFFFFFFFFFF00, stb:48'h000080000100, err:1'b0, vi:0, vv:16'hCCDD};
    tbl[2] = '{n:3, b:48'h845678000000, tx:48'hFFFFFF000000, stb:48'h000010000000, err:1'b0, vi:4, vv:16'h5678};
    tbl[3] = '{n:5, b:48'h430000000000, tx:48'h123456780000, stb:48'h0,            err:1'b0, vi:3, vv:16'h1234};
    tbl[4] = '{n:3, b:48'h8A1122000000, tx:48'h0,            stb:48'h0,            err:1'b1, vi:2, vv:16'h0000};
    tbl[5] = '{n:2, b:48'h3F0000000000, tx:48'h0,            stb:48'h0,            err:1'b0, vi:7, vv:16'hAABB};
    tbl[6] = '{n:4, b:48'h470000000000, tx:48'hAABBCCDD0000, stb:48'h0,            err:1'b0, vi:0, vv:16'hCCDD};
    tbl[7] = '{n:5, b:48'h810102030400, tx:48'hFFFFFFFFFF00, stb:48'h000002000200, err:1'b0, vi:1, vv:16'h0304};

    sys_rst = 1'b1; cs_active = 1'b0; rx_byte_valid = 1'b0; rx_byte = 8'h00; track = 1'b1;
    m_acc = 16'h0; m_tx = 8'h0; m_stb = 8'h0; m_idx = 0; m_pos = 0;
    m_reset();
    repeat (2) @(negedge clk);
    check("reset tx", 32'(tx_byte), 32'h0);
    check("reset stb", 32'(voice_wr_stb), 32'h0);
    check("reset err", 32'(cmd_err), 32'h0);
    check("reset voices", 32'(|voice_div), 32'h0);
    sys_rst = 1'b0;
    @(negedge clk);

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      frame_start();
      for (int j = 0; j < tbl[i].n; j++) begin
        send(tbl[i].b[47-8*j -: 8], j == 0, 1'b0);
        check($sformatf("vec%0d tx%0d", i, j), 32'(tx_byte), 32'(tbl[i].tx[47-8*j -: 8]));
        check($sformatf("vec%0d stb%0d", i, j), 32'(voice_wr_stb), 32'(tbl[i].stb[47-8*j -: 8]));
      end
      frame_end();
      check($sformatf("vec%0d err", i), 32'(cmd_err), 32'(tbl[i].err));
      check($sformatf("vec%0d voice", i), 32'(voice_div[tbl[i].vi*16 +: 16]), 32'(tbl[i].vv));
    end

    // Partial write abandoned by cs falling, then a fresh command decodes
    frame_start();
    send(8'h82, 1'b1, 1'b0);
    check("partial tx0", 32'(tx_byte), 32'hFF);
    send(8'h99, 1'b0, 1'b0);
    check("partial tx1", 32'(tx_byte), 32'hFF);
    check("partial stb", 32'(voice_wr_stb), 32'h0);
    frame_end();
    check("partial v2", 32'(voice_div[2*16 +: 16]), 32'h0);
    frame_start();
    send(8'h01, 1'b1, 1'b0);
    check("newcmd tx0", 32'(tx_byte), 32'h03);
    send(8'h00, 1'b0, 1'b0);
    check("newcmd tx1", 32'(tx_byte), 32'h04);
    frame_end();

    // Final byte coinciding with cs falling still commits; IDLE ignores bytes
    frame_start();
    send(8'h85, 1'b1, 1'b0);
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b1);
    check("drop stb", 32'(voice_wr_stb), 32'h20);
    check("drop v5", 32'(voice_div[5*16 +: 16]), 32'h1234);
    @(negedge clk);
    rx_byte_valid = 1'b1; rx_byte = 8'h99;
    @(negedge clk);
    rx_byte_valid = 1'b0;
    check("idle tx", 32'(tx_byte), 32'hFF);
    check("idle stb", 32'(voice_wr_stb), 32'h0);

    // Random frames against the model
    for (int f = 0; f < 40; f++) begin
      int          n;
      bit          drop;
      logic [7:0]  b;
      n    = 1 + $urandom_range(0, 5);
      drop = bit'($urandom_range(0, 1));
      frame_start();
      for (int j = 0; j < n; j++) begin
        if (j == 0) begin
          b[7:6] = 2'($urandom_range(0, 3));
          b[5:0] = ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom_range(0, 9));
        end else begin
          b = 8'($urandom);
        end
        send(b, j == 0, drop && (j == n - 1));
        check($sformatf("rnd%0d tx%0d", f, j), 32'(tx_byte), 32'(m_tx));
        check($sformatf("rnd%0d stb%0d", f, j), 32'(voice_wr_stb), 32'(m_stb));
      end
      if (drop) @(negedge clk);
      else      frame_end();
      check($sformatf("rnd%0d err", f), 32'(cmd_err), 32'(m_err));
      check_model_voices($sformatf("rnd%0d", f));
    end

    // Asynchronous reset mid-frame, then cs must drop before a frame is taken
    frame_start();
    send(8'h81, 1'b1, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    sys_rst = 1'b1;
    #1;
    check("arst voices", 32'(|voice_div), 32'h0);
    check("arst voices24", 32'(|voice_div24), 32'h0);
    check("arst tx", 32'(tx_byte), 32'h0);
    check("arst err", 32'(cmd_err), 32'h0);
    check("arst stb", 32'(voice_wr_stb), 32'h0);
    m_reset();
    @(negedge clk);
    sys_rst = 1'b0;
    track   = 1'b0;
    send(8'h83, 1'b1, 1'b0);
    send(8'h12, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0);
    check("unarmed tx", 32'(tx_byte), 32'h0);
    check("unarmed stb", 32'(voice_wr_stb), 32'h0);
    check("unarmed v3", 32'(voice_div[3*16 +: 16]), 32'h0);
    track = 1'b1;
    frame_end();

    // Three-byte registers: 24-bit instance alongside the model-tracked one
    frame_start();
    send(8'h83, 1'b1, 1'b0);
    check("w24 tx0", 32'(tx24), 32'hFF);
    check("w24 main tx0", 32'(tx_byte), 32'(m_tx));
    send(8'h12, 1'b0, 1'b0);
    check("w24 stb1", 32'(stb24), 32'h0);
    send(8'h34, 1'b0, 1'b0);
    check("w24 stb2", 32'(stb24), 32'h0);
    check("w24 main stb2", 32'(voice_wr_stb), 32'(m_stb));
    send(8'h56, 1'b0, 1'b0);
    check("w24 tx3", 32'(tx24), 32'hFF);
    check("w24 stb3", 32'(stb24), 32'h8);
    frame_end();
    check("w24 stb after", 32'(stb24), 32'h0);
    check("w24 v3", 32'(voice_div24[3*24 +: 24]), 32'h123456);
    check("w24 err", 32'(err24), 32'h0);
    check_model_voices("w24 main");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/spi_voice_regfile.md
SPI_VOICE_REGFILE -- requirements
Module: spi_voice_regfile

Interface
REQ-001 SHALL have parameter N_VOICES, default 8, number of voice divider registers (1..64).
REQ-002 SHALL have parameter D_W, default 16, register width in bits (multiple of 8, 8..32); BPR = D_W/8 bytes per register.
REQ-003 SHALL have parameter RESET_DIV, default 0, reset value of every register.
REQ-004 SHALL have parameter ACK_BYTE, default 8'hFF, reply byte for accepted command/write bytes; NAK byte fixed 8'h00.
REQ-005 SHALL have port sys_clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port cs_active  input  1  SPI frame active, level, synchronous to sys_clk.
REQ-008 SHALL have port rx_byte_valid  input  1  one-cycle pulse, new MOSI byte on rx_byte.
REQ-009 SHALL have port rx_byte  input  8  received byte, valid with rx_byte_valid.
REQ-010 SHALL have port tx_byte  output  8  byte shifted out on MISO during next transfer.
REQ-011 SHALL have port voice_div  output  N_VOICES*D_W  flattened registers, voice k at bits [k*D_W +: D_W].
REQ-012 SHALL have port voice_wr_stb  output  N_VOICES  one-cycle pulse on bit k when voice k updates.
REQ-013 SHALL have port cmd_err  output  1  sticky, set on any access to index >= N_VOICES.

Function
REQ-014 SHALL implement FSM states IDLE, CMD, DATA; IDLE->CMD when cs_active=1; CMD->DATA on rx_byte_valid; any state->IDLE when cs_active=0.
REQ-015 SHALL decode the first byte of a frame (in CMD) as: bit7 write(1)/read(0), bit6 auto-increment, bits[5:0] start index.
REQ-016 SHALL, in DATA, count bytes within a register with byte_idx 0..BPR-1, MSB byte first.
REQ-017 SHALL update tx_byte exactly 1 cycle after each rx_byte_valid pulse; tx_byte otherwise stable.
REQ-018 SHALL, on write, accumulate bytes in a shadow register and commit the full D_W word to voice[idx] only on receipt of byte BPR-1, pulsing voice_wr_stb[idx] in the commit cycle plus 1.
REQ-019 SHALL, on read, snapshot voice[idx] into a shift register when the command byte or the final byte of the previous register is received, and present its bytes MSB first on tx_byte.
REQ-020 SHALL, after each completed register, set idx to idx+1 (wrap N_VOICES-1 -> 0) if auto-increment, else keep idx.
REQ-021 SHALL reply ACK_BYTE after write command and write data bytes with valid idx.
REQ-022 SHALL, for idx >= N_VOICES: ignore writes, reply 8'h00 to every byte, set cmd_err; auto-increment from invalid idx wraps to 0.
REQ-023 SHALL discard partial write (byte_idx != 0) when cs_active falls; no register or strobe changes.
REQ-024 SHALL process an rx_byte_valid coinciding with cs_active falling (including commit), then enter IDLE.
REQ-025 SHALL ignore rx_byte_valid while in IDLE.
REQ-026 SHALL clear cmd_err only on reset or a read command of index 6'h3F.

Reset
REQ-027 SHALL, on sys_rst=1 (any state, mid-frame included), immediately set FSM=IDLE, byte_idx=0, all voice registers=RESET_DIV, tx_byte=8'h00, voice_wr_stb=0, cmd_err=0.
REQ-028 SHALL require cs_active to go low before a new frame is accepted after reset release.

Verification
REQ-029 Write frame 0x83,0x12,0x34 (defaults) -> voice 3 = 16'h1234, voice_wr_stb=8'b0000_1000 for one cycle, tx_byte ACK 0xFF after each byte.
REQ-030 Auto-inc write 0xC7,0xAA,0xBB,0xCC,0xDD -> voice7=16'hAABB, voice0=16'hCCDD (wrap), two strobes.
REQ-031 Read 0x43 with voice3=16'h1234, voice4=16'h5678, four dummy bytes -> tx_byte sequence 0x12,0x34,0x56,0x78.
REQ-032 Write 0x82,0x99 then cs_active low -> voice2 unchanged, no strobe; next frame decodes as new command.
REQ-033 Write 0x8A,0x11,0x22 (N_VOICES=8) -> no register change, tx_byte 0x00, cmd_err=1; read 0x3F clears it.
REQ-034 Assert sys_rst after 0x81,0x55 -> all voice_div=RESET_DIV at once; repeat REQ-029 with D_W=24, N_VOICES=4 (3-byte registers).
